// File: rtl/reg_status_table.sv
// Per-register pending-write tracker with ROB tags.
// Answers rs1/rs2 dependency lookups and drives the regfile write port.
module reg_status_table #(
  parameter int ROB_WIDTH = 3
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 rdy_in,
  input  logic                 flush_pipline,
  input  logic                 issue_valid,
  input  logic [4:0]           issue_rd_id,
  input  logic [ROB_WIDTH-1:0] issue_rob_tag,
  input  logic [4:0]           rs1_reg_id,
  output logic                 rs1_busy,
  output logic [ROB_WIDTH-1:0] rs1_tag,
  input  logic [4:0]           rs2_reg_id,
  output logic                 rs2_busy,
  output logic [ROB_WIDTH-1:0] rs2_tag,
  input  logic                 commit_valid,
  input  logic [4:0]           commit_rd_id,
  input  logic [ROB_WIDTH-1:0] commit_rob_tag,
  input  logic [31:0]          commit_val,
  output logic                 is_writing_rd,
  output logic [4:0]           rd_reg_id,
  output logic [31:0]          rd_val,
  output logic [5:0]           busy_count
);

  logic [31:0]          busy;
  logic [ROB_WIDTH-1:0] tag [32];

  logic       iss;
  logic       com;
  logic       clr;
  logic       inc;
  logic [5:0] cnt_nxt;

  assign iss = issue_valid && rdy_in && !flush_pipline
             && (issue_rd_id != 5'd0);
  assign com = commit_valid && rdy_in
             && (commit_rd_id != 5'd0);

  // A same-register issue renames over the commit, so it cannot clear.
  assign clr = com && busy[commit_rd_id]
             && (tag[commit_rd_id] == commit_rob_tag)
             && !(iss && (issue_rd_id == commit_rd_id));
  assign inc = iss && !busy[issue_rd_id];

  always_comb begin
    cnt_nxt = busy_count;
    unique case (1'b1)
      inc && !clr: cnt_nxt = busy_count + 6'd1;
      clr && !inc: cnt_nxt = busy_count - 6'd1;
      default:     cnt_nxt = busy_count;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      busy       <= '0;
      busy_count <= '0;
      for (int i = 0; i < 32; i++) tag[i] <= '0;
    end else if (rdy_in) begin
      if (flush_pipline) begin
        busy       <= '0;
        busy_count <= '0;
      end else begin
        if (clr) busy[commit_rd_id] <= 1'b0;
        if (iss) begin
          busy[issue_rd_id] <= 1'b1;
          tag[issue_rd_id]  <= issue_rob_tag;
        end
        busy_count <= cnt_nxt;
      end
    end
  end

  always_comb begin
    rs1_busy = 1'b0;
    rs1_tag  = '0;
    rs2_busy = 1'b0;
    rs2_tag  = '0;
    if (rs1_reg_id != 5'd0) begin
      rs1_busy = busy[rs1_reg_id];
      rs1_tag  = tag[rs1_reg_id];
    end
    if (rs2_reg_id != 5'd0) begin
      rs2_busy = busy[rs2_reg_id];
      rs2_tag  = tag[rs2_reg_id];
    end
  end

  assign is_writing_rd = rst_n_in && rdy_in && commit_valid
                       && (commit_rd_id != 5'd0);
  assign rd_reg_id     = commit_rd_id;
  assign rd_val        = commit_val;

endmodule

// File: tb/tb_reg_status_table.sv
// Directed + random bench for reg_status_table.
// Reference model keeps busy/tag per register as plain arrays.
module tb_reg_status_table;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        rdy_in;
  logic        flush_pipline;
  logic        issue_valid;
  logic [4:0]  issue_rd_id;
  logic [2:0]  issue_rob_tag;
  logic [4:0]  rs1_reg_id;
  logic        rs1_busy;
  logic [2:0]  rs1_tag;
  logic [4:0]  rs2_reg_id;
  logic        rs2_busy;
  logic [2:0]  rs2_tag;
  logic        commit_valid;
  logic [4:0]  commit_rd_id;
  logic [2:0]  commit_rob_tag;
  logic [31:0] commit_val;
  logic        is_writing_rd;
  logic [4:0]  rd_reg_id;
  logic [31:0] rd_val;
  logic [5:0]  busy_count;

  reg_status_table #(.ROB_WIDTH(3)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
    .flush_pipline(flush_pipline),
    .issue_valid(issue_valid), .issue_rd_id(issue_rd_id),
    .issue_rob_tag(issue_rob_tag),
    .rs1_reg_id(rs1_reg_id), .rs1_busy(rs1_busy), .rs1_tag(rs1_tag),
    .rs2_reg_id(rs2_reg_id), .rs2_busy(rs2_busy), .rs2_tag(rs2_tag),
    .commit_valid(commit_valid), .commit_rd_id(commit_rd_id),
    .commit_rob_tag(commit_rob_tag), .commit_val(commit_val),
    .is_writing_rd(is_writing_rd), .rd_reg_id(rd_reg_id),
    .rd_val(rd_val), .busy_count(busy_count)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;
  bit mb [32];
  int mt [32];

  task automatic check(input string n, input logic [31:0] o,
                       input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", n, o, e);
    end
  endtask

  function automatic int pop();
    int s = 0;
    for (int i = 1; i < 32; i++) s += int'(mb[i]);
    return s;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      mb[i] = 1'b0;
      mt[i] = 0;
    end
  endtask

  task automatic look(input int r1, input int r2);
    check("rs1_busy", rs1_busy, mb[r1]);
    if (mb[r1] || r1 == 0) check("rs1_tag", rs1_tag, mt[r1]);
    check("rs2_busy", rs2_busy, mb[r2]);
    if (mb[r2] || r2 == 0) check("rs2_tag", rs2_tag, mt[r2]);
    check("busy_count", busy_count, pop());
  endtask

  // One clock: drive after negedge, check, then advance model at posedge.
  task automatic cyc(input bit iv, input int ird, input int itag,
                     input bit cv, input int crd, input int ctag,
                     input logic [31:0] cval, input bit fl,
                     input bit rdy, input int r1, input int r2);
    issue_valid    = iv;
    issue_rd_id    = 5'(ird);
    issue_rob_tag  = 3'(itag);
    commit_valid   = cv;
    commit_rd_id   = 5'(crd);
    commit_rob_tag = 3'(ctag);
    commit_val     = cval;
    flush_pipline  = fl;
    rdy_in         = rdy;
    rs1_reg_id     = 5'(r1);
    rs2_reg_id     = 5'(r2);
    #1;
    look(r1, r2);
    check("wr_en", is_writing_rd, rdy && cv && crd != 0);
    check("wr_id", rd_reg_id, crd);
    check("wr_val", rd_val, cval);
    @(posedge clk_in);
    if (rdy) begin
      if (cv && crd != 0 && mb[crd] && mt[crd] == ctag) mb[crd] = 1'b0;
      if (fl) begin
        for (int i = 0; i < 32; i++) mb[i] = 1'b0;
      end else if (iv && ird != 0) begin
        mb[ird] = 1'b1;
        mt[ird] = itag;
      end
    end
    @(negedge clk_in);
  endtask

  task automatic idle(input int r1, input int r2);
    cyc(0, 0, 0, 0, 0, 0, 32'h0, 0, 1, r1, r2);
  endtask

  initial begin
    rst_n_in = 1'b0;
    model_reset();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    rst_n_in = 1'b0;
    commit_valid = 1'b1;
    commit_rd_id = 5'd3;
    rs1_reg_id = 5'd5;
    rs2_reg_id = 5'd0;
    #1;
    check("rst_wr_en", is_writing_rd, 1'b0);
    check("rst_rs1_busy", rs1_busy, 1'b0);
    check("rst_rs1_tag", rs1_tag, 3'd0);
    check("rst_count", busy_count, 6'd0);
    @(negedge clk_in);
    rst_n_in = 1'b1;

    // Issue then lookup
    cyc(1, 5, 3, 0, 0, 0, 0, 0, 1, 5, 0);
    idle(5, 0);
    check("x5_tag3", rs1_tag, 3'd3);
    check("cnt_1", busy_count, 6'd1);

    // Rename, stale commit, then matching commit
    cyc(1, 5, 6, 0, 0, 0, 0, 0, 1, 5, 5);
    cyc(0, 0, 0, 1, 5, 3, 32'hAAAA, 0, 1, 5, 0);
    idle(5, 0);
    check("x5_still_busy", rs1_busy, 1'b1);
    check("x5_tag6", rs1_tag, 3'd6);
    cyc(0, 0, 0, 1, 5, 6, 32'h5555, 0, 1, 5, 0);
    idle(5, 0);
    check("x5_free", rs1_busy, 1'b0);
    check("cnt_0", busy_count, 6'd0);

    // Same-cycle issue and commit to x7: issue wins
    cyc(1, 7, 1, 0, 0, 0, 0, 0, 1, 7, 0);
    cyc(1, 7, 2, 1, 7, 1, 32'h77, 0, 1, 7, 0);
    idle(7, 0);
    check("x7_tag2", rs1_tag, 3'd2);
    check("x7_cnt", busy_count, 6'd1);

    // x0 is inert
    cyc(1, 0, 4, 1, 0, 4, 32'h99, 0, 1, 0, 0);
    idle(0, 0);

    // Fill all registers, then flush with a commit
    for (int r = 1; r < 32; r++) cyc(1, r, r % 8, 0, 0, 0, 0, 0, 1, r, 0);
    idle(1, 31);
    check("cnt_31", busy_count, 6'd31);
    cyc(0, 0, 0, 1, 9, 0, 32'h1234, 1, 1, 9, 1);
    idle(9, 31);
    check("flush_cnt", busy_count, 6'd0);

    // rdy low holds state
    cyc(1, 4, 5, 0, 0, 0, 0, 0, 1, 4, 0);
    cyc(1, 6, 2, 1, 4, 5, 32'h44, 0, 0, 4, 6);
    idle(4, 6);

    // Asynchronous reset mid-cycle
    #2;
    rst_n_in = 1'b0;
    #1;
    model_reset();
    check("async_cnt", busy_count, 6'd0);
    check("async_rs1", rs1_busy, 1'b0);
    check("async_tag", rs1_tag, 3'd0);
    @(negedge clk_in);
    rst_n_in = 1'b1;

    // Random traffic on a small register window to force collisions
    for (int n = 0; n < 600; n++) begin
      int ird, crd, ctag;
      ird = $urandom_range(0, 7);
      crd = $urandom_range(0, 7);
      ctag = ($urandom_range(0, 1) == 1) ? mt[crd] : $urandom_range(0, 7);
      cyc($urandom_range(0, 1), ird, $urandom_range(0, 7),
          $urandom_range(0, 1), crd, ctag, $urandom,
          $urandom_range(0, 40) == 0, $urandom_range(0, 9) != 0,
          $urandom_range(0, 8), $urandom_range(0, 8));
    end
    idle(1, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_status_table.md
# reg_status_table

Register dependency tracker and write-port sequencer in front of the 32×32 register file. For each architectural register it records whether a write is pending and which ROB entry will produce it. It answers the issue stage's rs1/rs2 dependency queries. It drives the register file's single write port from the ROB commit stream and clears pending state on `flush_pipline`.

## Interface
- `ROB_WIDTH`, 3, width of the ROB tag (supports 2^ROB_WIDTH ROB entries).
- `clk_in`  input  1  system clock; all state updates on the rising edge.
- `rst_n_in`  input  1  reset: asynchronous, active-low.
- `rdy_in`  input  1  ready; when low, all state holds and no register-file write is issued.
- `flush_pipline`  input  1  misprediction flush; clears all pending state at the next edge.
- `issue_valid`  input  1  an instruction with a destination is being issued this cycle.
- `issue_rd_id`  input  5  destination register of the issuing instruction.
- `issue_rob_tag`  input  ROB_WIDTH  ROB entry allocated to the issuing instruction.
- `rs1_reg_id`  input  5  source-1 register to look up.
- `rs1_busy`  output  1  source-1 has a pending write.
- `rs1_tag`  output  ROB_WIDTH  ROB entry producing source-1 (meaningful only when `rs1_busy` is 1).
- `rs2_reg_id`  input  5  source-2 register to look up.
- `rs2_busy`  output  1  source-2 has a pending write.
- `rs2_tag`  output  ROB_WIDTH  ROB entry producing source-2 (meaningful only when `rs2_busy` is 1).
- `commit_valid`  input  1  ROB head is committing a register result this cycle.
- `commit_rd_id`  input  5  destination of the committing instruction.
- `commit_rob_tag`  input  ROB_WIDTH  ROB entry being committed.
- `commit_val`  input  32  result value being committed.
- `is_writing_rd`  output  1  register-file write enable.
- `rd_reg_id`  output  5  register-file write address.
- `rd_val`  output  32  register-file write data.
- `busy_count`  output  6  number of registers currently marked busy (0..31).

## Operation
- State per register r in 1..31: `busy[r]` (1 bit) and `tag[r]` (ROB_WIDTH bits).
- Register x0 is never busy.
- Lookups are combinational from the current state only.
  - `rsN_busy = busy[rsN_reg_id]` and `rsN_tag = tag[rsN_reg_id]`.
  - x0 always returns busy 0 and tag 0.
  - A same-cycle issue or commit is not visible until after the edge.
- Issue (`issue_valid` && `rdy_in` && !`flush_pipline` && `issue_rd_id`≠0):
  - `busy[rd] <= 1` and `tag[rd] <= issue_rob_tag`.
  - This overwrites any older pending tag; it is a rename.
- Commit (`commit_valid` && `rdy_in` && `commit_rd_id`≠0):
  - The register file is always written with `commit_val`.
  - `busy[rd]` is cleared only if `tag[rd] == commit_rob_tag`.
  - On a tag mismatch a younger writer is pending, and `busy`/`tag` remain unchanged.
- Issue and commit to the same register in the same cycle: issue wins, giving busy=1 and tag=issue tag.
- Flush: at the edge, every `busy[r] <= 0`. Tags are left as they are (don't-care).
  - A commit in the flush cycle still writes the register file; committed state is architectural.
  - An issue in the flush cycle is discarded.
- `rdy_in` low: no state change and `is_writing_rd`=0. Inputs are ignored.
- Write port, combinational:
  - `is_writing_rd` = `rst_n_in` && `rdy_in` && `commit_valid` && `commit_rd_id`≠0.
  - `rd_reg_id` = `commit_rd_id`.
  - `rd_val` = `commit_val`.
- `busy_count` is a registered population count of `busy[1..31]`.
  - It is updated incrementally each edge by +1 (issue to a non-busy register), −1 (matching commit, when not overridden by an issue to the same register), or 0.
  - It goes to 0 on flush.
  - It must never underflow or exceed 31.

## Timing
- Reset (asynchronous, `rst_n_in`=0):
  - All `busy`=0, all `tag`=0, `busy_count`=0.
  - `is_writing_rd`=0 while reset is held.
  - Lookups return busy 0 and tag 0.
- Issue-to-visible latency: 1 cycle. A lookup in the cycle after the issue edge sees busy=1.
- Commit clear latency: 1 cycle. The register file is written at the same edge that busy clears, so the first cycle with busy=0 reads the new value from the register file.
- Flush: busy is all-zero in the cycle after the flush edge.
- Reset asserted mid-operation clears all state immediately, without waiting for an edge.

## Test plan
- Reset, then look up x5 → busy 0, tag 0, `busy_count` 0. Issue rd=5, tag=3 → next cycle rs1=x5 returns busy 1, tag 3, and `busy_count` is 1.
- Issue x5/tag 3, then x5/tag 6. Commit x5/tag 3, val 0xAAAA → reg-file write of 0xAAAA occurs; x5 stays busy with tag 6 and `busy_count` stays 1. Commit x5/tag 6 → busy 0, `busy_count` 0.
- In one cycle, issue x7/tag 2 and commit x7/tag 1 (x7 previously busy with tag 1) → x7 busy with tag 2, `busy_count` unchanged.
- Issue x0/tag 4 and commit x0 → no state change, `is_writing_rd`=0, x0 lookups return busy 0.
- Make x1..x31 busy (`busy_count`=31), then assert flush together with commit x9/val 0x1234 → write of 0x1234 is issued; next cycle all busy=0 and `busy_count`=0.
- With `rdy_in`=0, apply issue and commit → no state change, `is_writing_rd`=0. Assert reset mid-sequence → state clears immediately.
